// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: data memory enable/strobe, pipeline stall, flush, halt and error tracking.
// Define MEM_STAGE_CTRL_TIMEOUT_EN to compile in a 4-bit watchdog on the WAIT state.
module mem_stage_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_wrt_in,
  input  logic        branchtake_in,
  input  logic        halt_in,
  input  logic        mem_done,
  input  logic        mem_err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic        pipe_stall,
  output logic        flush,
  output logic        send_nop,
  output logic        halt_out,
  output logic        err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        wr_q;
  logic        err_q;
  logic [15:0] cnt_q;

  logic        req;
  logic        en_c;
  logic        wr_c;
  logic        stall_c;
  logic        flush_c;
  logic        halt_c;
  logic        err_set;
  logic        to_expire;

  assign req = valid_in & (mem_read_in | mem_wrt_in);

`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
  logic [3:0] to_q;

  // Fifteenth WAIT cycle without completion trips the watchdog.
  assign to_expire = (to_q == 4'd14);

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_q <= 4'd0;
    end else if (state != WAIT) begin
      to_q <= 4'd0;
    end else if (!mem_done) begin
      to_q <= to_q + 4'd1;
    end
  end
`else
  assign to_expire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    en_c      = 1'b0;
    wr_c      = 1'b0;
    stall_c   = 1'b0;
    flush_c   = 1'b0;
    halt_c    = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        en_c = req;
        wr_c = req & mem_wrt_in;
        if (req && mem_err) begin
          stall_c   = 1'b1;
          err_set   = 1'b1;
          state_nxt = HALTED;
        end else if (req && !mem_done) begin
          stall_c   = 1'b1;
          state_nxt = WAIT;
        end else if (valid_in && halt_in) begin
          state_nxt = HALTED;
        end
        flush_c = valid_in & branchtake_in & ~halt_in & ~stall_c;
      end
      WAIT: begin
        en_c = 1'b1;
        wr_c = wr_q;
        // A fault overrides a simultaneous completion.
        if (mem_err) begin
          stall_c   = 1'b1;
          err_set   = 1'b1;
          state_nxt = HALTED;
        end else if (mem_done) begin
          state_nxt = IDLE;
        end else begin
          stall_c = 1'b1;
          if (to_expire) begin
            err_set   = 1'b1;
            state_nxt = HALTED;
          end
        end
        flush_c = valid_in & branchtake_in & ~halt_in & ~stall_c;
      end
      HALTED: begin
        stall_c = 1'b1;
        halt_c  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      wr_q  <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == WAIT) wr_q <= mem_wrt_in;
      if (err_set) err_q <= 1'b1;
      if (stall_c && state != HALTED && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  // Reset forces every single-bit output low, even in the middle of an access.
  assign mem_en     = rst & en_c;
  assign mem_wr     = rst & wr_c;
  assign pipe_stall = rst & stall_c;
  assign send_nop   = rst & stall_c;
  assign flush      = rst & flush_c;
  assign halt_out   = rst & halt_c;
  assign err        = rst & err_q;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: inputs change 1 ns after the rising edge, outputs are checked 1 ns later.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_read_in, mem_wrt_in, branchtake_in, halt_in, mem_done, mem_err;
  logic        mem_en, mem_wr, pipe_stall, flush, send_nop, halt_out, err;
  logic [15:0] stall_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .mem_read_in   (mem_read_in),
    .mem_wrt_in    (mem_wrt_in),
    .branchtake_in (branchtake_in),
    .halt_in       (halt_in),
    .mem_done      (mem_done),
    .mem_err       (mem_err),
    .mem_en        (mem_en),
    .mem_wr        (mem_wr),
    .pipe_stall    (pipe_stall),
    .flush         (flush),
    .send_nop      (send_nop),
    .halt_out      (halt_out),
    .err           (err),
    .stall_cnt     (stall_cnt)
  );

  task automatic chk1(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive inputs {valid, read, write, branch, halt, done, err}, then let combinational outputs settle.
  task automatic apply(input logic v, input logic rd, input logic wr, input logic br,
                       input logic hl, input logic dn, input logic er);
    valid_in = v; mem_read_in = rd; mem_wrt_in = wr; branchtake_in = br;
    halt_in = hl; mem_done = dn; mem_err = er;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    apply(1, 1, 0, 1, 0, 0, 0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_stall", pipe_stall, 1'b0);
    chk1("rst_flush", flush, 1'b0);
    step();
    chk16("rst_stall_cnt", stall_cnt, 16'd0);
    chk1("rst_err", err, 1'b0);
    rst = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0);
    step();

    // Load completing in the same cycle.
    apply(1, 1, 0, 0, 0, 1, 0);
    chk1("ld_fast_en", mem_en, 1'b1);
    chk1("ld_fast_wr", mem_wr, 1'b0);
    chk1("ld_fast_stall", pipe_stall, 1'b0);
    chk1("ld_fast_nop", send_nop, 1'b0);
    step();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk16("ld_fast_cnt", stall_cnt, 16'd0);
    chk1("idle_en", mem_en, 1'b0);

    // Store completing after three stall cycles; write input dropped in WAIT to prove latching.
    apply(1, 0, 1, 0, 0, 0, 0);
    chk1("st_c0_wr", mem_wr, 1'b1);
    chk1("st_c0_stall", pipe_stall, 1'b1);
    chk1("st_c0_nop", send_nop, 1'b1);
    step();
    apply(1, 0, 0, 0, 0, 0, 0);
    chk1("st_c1_en", mem_en, 1'b1);
    chk1("st_c1_wr_latched", mem_wr, 1'b1);
    chk1("st_c1_stall", pipe_stall, 1'b1);
    step();
    apply(1, 0, 1, 0, 0, 0, 0);
    chk1("st_c2_wr", mem_wr, 1'b1);
    chk1("st_c2_stall", pipe_stall, 1'b1);
    step();
    apply(1, 0, 1, 0, 0, 1, 0);
    chk1("st_c3_wr", mem_wr, 1'b1);
    chk1("st_c3_stall", pipe_stall, 1'b0);
    chk1("st_c3_nop", send_nop, 1'b0);
    step();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk16("st_cnt", stall_cnt, 16'd3);
    chk1("st_back_idle_en", mem_en, 1'b0);
    chk1("st_back_idle_wr", mem_wr, 1'b0);

    // Taken branch alone, then with a stalled load.
    apply(1, 0, 0, 1, 0, 0, 0);
    chk1("br_flush", flush, 1'b1);
    chk1("br_stall", pipe_stall, 1'b0);
    step();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk1("br_flush_one_cycle", flush, 1'b0);
    apply(1, 1, 0, 1, 0, 0, 0);
    chk1("brld_c0_flush", flush, 1'b0);
    step();
    chk1("brld_c1_flush", flush, 1'b0);
    chk1("brld_c1_stall", pipe_stall, 1'b1);
    step();
    apply(1, 1, 0, 1, 0, 1, 0);
    chk1("brld_release_flush", flush, 1'b1);
    chk1("brld_release_stall", pipe_stall, 1'b0);
    step();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk1("brld_after_flush", flush, 1'b0);
    chk16("brld_cnt", stall_cnt, 16'd5);

    // valid_in low masks everything, including a fault.
    apply(0, 1, 1, 1, 1, 0, 1);
    chk1("inv_en", mem_en, 1'b0);
    chk1("inv_flush", flush, 1'b0);
    chk1("inv_stall", pipe_stall, 1'b0);
    step();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk1("inv_halt", halt_out, 1'b0);
    chk1("inv_err", err, 1'b0);

    // Halt together with a taken branch: halt wins.
    apply(1, 0, 0, 1, 1, 0, 0);
    chk1("hlt_flush", flush, 1'b0);
    chk1("hlt_halt_same", halt_out, 1'b0);
    step();
    apply(1, 1, 0, 1, 0, 1, 0);
    chk1("hlt_halt", halt_out, 1'b1);
    chk1("hlt_en", mem_en, 1'b0);
    chk1("hlt_flush2", flush, 1'b0);
    chk1("hlt_stall", pipe_stall, 1'b1);
    chk1("hlt_nop", send_nop, 1'b1);
    step();
    step();
    chk1("hlt_held", halt_out, 1'b1);
    chk16("hlt_no_count", stall_cnt, 16'd5);

    // Reset leaves HALTED.
    rst = 1'b0;
    #1;
    chk1("rst_hlt_out", halt_out, 1'b0);
    chk1("rst_hlt_stall", pipe_stall, 1'b0);
    step();
    rst = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0);
    chk1("post_rst_halt", halt_out, 1'b0);
    chk16("post_rst_cnt", stall_cnt, 16'd0);

    // Fault during WAIT.
    apply(1, 1, 0, 0, 0, 0, 0);
    step();
    apply(1, 1, 0, 0, 0, 1, 1);
    chk1("err_cyc_stall", pipe_stall, 1'b1);
    chk1("err_cyc_err", err, 1'b0);
    step();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk1("err_set", err, 1'b1);
    chk1("err_halted", halt_out, 1'b1);
    step();
    chk1("err_sticky", err, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk1("err_cleared", err, 1'b0);
    chk1("err_rst_idle", halt_out, 1'b0);
    chk16("err_rst_cnt", stall_cnt, 16'd0);

    // Reset in the middle of WAIT abandons the access.
    apply(1, 0, 1, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    #1;
    chk1("rstw_en", mem_en, 1'b0);
    chk1("rstw_wr", mem_wr, 1'b0);
    chk1("rstw_nop", send_nop, 1'b0);
    step();
    rst = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0);
    chk1("rstw_idle_en", mem_en, 1'b0);
    chk16("rstw_cnt", stall_cnt, 16'd0);

    // Memory that never answers.
    apply(1, 1, 0, 0, 0, 0, 0);
`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step();
    chk1("to_not_yet", err, 1'b0);
    step();
    chk1("to_err", err, 1'b1);
    chk1("to_halted", halt_out, 1'b1);
    chk16("to_cnt", stall_cnt, 16'd16);
`else
    for (int i = 0; i < 100; i++) step();
    chk1("nto_en", mem_en, 1'b1);
    chk1("nto_stall", pipe_stall, 1'b1);
    chk1("nto_err", err, 1'b0);
    chk1("nto_halt", halt_out, 1'b0);
    chk16("nto_cnt", stall_cnt, 16'd100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
